div_ctrl: RTL and testbench

Multi-cycle divide controller and iterative 32-bit divider for the EX stage. It accepts one DIV/MOD request from the valid EX instruction and runs a 32-step restoring division. It holds `div_stop` high toward the hazard unit, which converts it into `stallE`, until the result is presented. The result is held until the EX stage can advance.

---
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_ctrl.sv | 108 ++++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-stage divide request/result bundle
interface div_ctrl_if #(parameter int DATA_W = 32);
    logic              es_valid;
    logic              div_req;
    logic              div_signed;
    logic [DATA_W-1:0] div_src1;
    logic [DATA_W-1:0] div_src2;
    logic              es_flush;
    logic              es_out_allowin;
    logic              div_stop;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;

    modport master (
        output es_valid, div_req, div_signed, div_src1, div_src2, es_flush, es_out_allowin,
        input  div_stop, div_done, div_quot, div_rem
    );

    modport slave (
        input  es_valid, div_req, div_signed, div_src1, div_src2, es_flush, es_out_allowin,
        output div_stop, div_done, div_quot, div_rem
    );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle restoring divider with EX-stage stall control
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_ctrl_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rem;
    logic              q_neg;
    logic              r_neg;
    logic              done_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;

    logic              go;
    logic              neg1;
    logic              neg2;
    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;
    logic [DATA_W:0]   part;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] q_next;
    logic [DATA_W-1:0] r_next;

    assign go           = bus.es_valid & bus.div_req & ~bus.es_flush;
    assign bus.div_stop = ((state == IDLE) & go) | ((state == CALC) & ~bus.es_flush);
    assign bus.div_done = done_q;
    assign bus.div_quot = quot_q;
    assign bus.div_rem  = rem_q;

    always_comb begin
        neg1 = bus.div_signed & bus.div_src1[DATA_W-1];
        neg2 = bus.div_signed & bus.div_src2[DATA_W-1];
        abs1 = neg1 ? -bus.div_src1 : bus.div_src1;
        abs2 = neg2 ? -bus.div_src2 : bus.div_src2;
    end

    // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB.
    always_comb begin
        part   = {rem, dvd[DATA_W-1]};
        diff   = part - {1'b0, dvs};
        q_bit  = (part >= {1'b0, dvs});
        r_next = q_bit ? diff[DATA_W-1:0] : part[DATA_W-1:0];
        q_next = {dvd[DATA_W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (bus.es_flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        dvd   <= abs1;
                        dvs   <= abs2;
                        rem   <= '0;
                        q_neg <= bus.div_signed & (bus.div_src1[DATA_W-1] ^ bus.div_src2[DATA_W-1]);
                        r_neg <= bus.div_signed & bus.div_src1[DATA_W-1];
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    dvd <= q_next;
                    rem <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        quot_q <= q_neg ? -q_next : q_next;
                        rem_q  <= r_neg ? -r_next : r_next;
                    end
                end
                DONE: begin
                    // A still-high div_req here belongs to the retiring instruction.
                    if (bus.es_out_allowin) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed scoreboard bench for div_ctrl
module tb_div_ctrl;
    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit chain);
        int          cyc;
        int          stop_cnt;
        logic [63:0] exp;
        bus.es_valid       = 1'b1;
        bus.div_req        = 1'b1;
        bus.div_signed     = sg;
        bus.div_src1       = a;
        bus.div_src2       = b;
        bus.es_out_allowin = 1'b0;
        sb.push_back(model(sg, a, b));
        cyc      = 0;
        stop_cnt = 0;
        #1;
        while (!bus.div_done && cyc < 100) begin
            if (bus.div_stop) stop_cnt++;
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 33);
        check("stop_cycles", stop_cnt, 33);
        check("stop_in_done", {31'd0, bus.div_stop}, 32'd0);
        exp = sb[0];
        for (int h = 0; h < hold; h++) begin
            check("hold_done", {31'd0, bus.div_done}, 32'd1);
            check("hold_stop", {31'd0, bus.div_stop}, 32'd0);
            check("hold_quot", bus.div_quot, exp[63:32]);
            check("hold_rem", bus.div_rem, exp[31:0]);
            @(negedge clk);
        end
        bus.es_out_allowin = 1'b1;
        exp = sb.pop_front();
        check("quot", bus.div_quot, exp[63:32]);
        check("rem", bus.div_rem, exp[31:0]);
        @(negedge clk);
        bus.es_out_allowin = 1'b0;
        if (chain) begin
            #1;
            check("chain_restart_stop", {31'd0, bus.div_stop}, 32'd1);
            check("chain_done_clear", {31'd0, bus.div_done}, 32'd0);
        end else begin
            bus.es_valid = 1'b0;
            bus.div_req  = 1'b0;
            #1;
            check("idle_done", {31'd0, bus.div_done}, 32'd0);
            check("idle_stop", {31'd0, bus.div_stop}, 32'd0);
        end
    endtask

    initial begin
        bit seen_done;
        resetn             = 1'b0;
        bus.es_valid       = 1'b0;
        bus.div_req        = 1'b0;
        bus.div_signed     = 1'b0;
        bus.div_src1       = '0;
        bus.div_src2       = '0;
        bus.es_flush       = 1'b0;
        bus.es_out_allowin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, bus.div_done}, 32'd0);
        check("rst_stop", {31'd0, bus.div_stop}, 32'd0);
        check("rst_quot", bus.div_quot, 32'd0);
        check("rst_rem", bus.div_rem, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, 0, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_div(1'b0, 32'd5, 32'd0, 0, 0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_div(1'($urandom_range(1)), $urandom, $urandom_range(100000) + 1, 0, 0);
        end

        run_div(1'b0, 32'd1000, 32'd10, 4, 1);
        run_div(1'b1, 32'hFFFF_FC18, 32'd33, 0, 0);

        bus.es_valid   = 1'b1;
        bus.div_req    = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd1000;
        bus.div_src2   = 32'd3;
        repeat (10) @(negedge clk);
        bus.es_flush = 1'b1;
        #1;
        check("flush_stop", {31'd0, bus.div_stop}, 32'd0);
        @(negedge clk);
        bus.es_flush = 1'b0;
        bus.es_valid = 1'b0;
        bus.div_req  = 1'b0;
        #1;
        check("flush_idle_done", {31'd0, bus.div_done}, 32'd0);
        check("flush_idle_stop", {31'd0, bus.div_stop}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_done) seen_done = 1'b1;
        end
        check("flush_no_done", {31'd0, seen_done}, 32'd0);

        bus.es_valid = 1'b1;
        bus.div_req  = 1'b1;
        bus.div_src1 = 32'd1000;
        bus.div_src2 = 32'd3;
        repeat (5) @(negedge clk);
        resetn       = 1'b0;
        bus.es_valid = 1'b0;
        bus.div_req  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("mid_rst_done", {31'd0, bus.div_done}, 32'd0);
        check("mid_rst_stop", {31'd0, bus.div_stop}, 32'd0);
        check("mid_rst_quot", bus.div_quot, 32'd0);
        check("mid_rst_rem", bus.div_rem, 32'd0);
        @(negedge clk);
        run_div(1'b0, 32'd9, 32'd3, 0, 0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
